// File: rtl/rot_enc_home_seq_pkg.sv
// Shared types and constants for the encoder homing sequencer.
package rot_enc_home_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        WAIT_RDY,
        ARM,
        SEARCH,
        LOAD_LO,
        LOAD_HI,
        DONE,
        FAIL
    } state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
    localparam logic [1:0] FAIL_ENC_ERR = 2'd2;
    localparam logic [1:0] FAIL_ABORT   = 2'd3;

    localparam logic PRESET_LO = 1'b0;
    localparam logic PRESET_HI = 1'b1;

    // Preset that makes the index position read home: home + distance travelled since index.
    function automatic logic signed [31:0] calc_preset(input logic signed [31:0] home,
                                                       input logic signed [31:0] counter,
                                                       input logic signed [31:0] z_pos);
        return home + (counter - z_pos);
    endfunction

endpackage

// File: rtl/rot_enc_home_timer.sv
// Loadable down-counter for the homing run timeout; a loaded value of 0 never expires.
module rot_enc_home_timer #(
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 load,
    input  logic [TIMEOUT_W-1:0] load_value,
    input  logic                 dec,
    output logic                 expire
);

    localparam logic [TIMEOUT_W-1:0] ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] count;

    // Load at run start, count down while enabled, park at 0 (disabled).
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expire = dec && (count == ONE);

endmodule

// File: rtl/rot_enc_home_seq.sv
// Homing sequencer and preset write-port arbiter for one quadrature encoder channel.
module rot_enc_home_seq
    import rot_enc_home_seq_pkg::*;
#(
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] timeout_ticks,
    input  logic signed [31:0]   home_value,
    input  logic                 cpu_addr,
    input  logic [1:0]           cpu_be,
    input  logic                 cpu_write,
    input  logic [15:0]          cpu_data,
    input  logic                 enc_ready,
    input  logic                 enc_error,
    input  logic                 enc_Z_flag,
    input  logic signed [31:0]   enc_Z_pos,
    input  logic signed [31:0]   enc_counter,
    output logic                 enc_sclr,
    output logic                 enc_ena,
    output logic                 enc_Z_clr,
    output logic                 enc_addr,
    output logic [1:0]           enc_be,
    output logic                 enc_write,
    output logic [15:0]          enc_data,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic signed [31:0]   index_pos,
    output logic                 cpu_wr_drop
);

    state_t             state, next_state;
    logic [1:0]         fail_cause;
    logic               tmr_expire;
    logic               run_start;
    logic signed [31:0] home_q, preset_q, preset_now;

    logic               sclr_d, ena_d, zclr_d, addr_d, write_d, busy_d, done_d, fail_d, drop_d;
    logic [1:0]         be_d, fail_code_d;
    logic [15:0]        data_d;
    logic signed [31:0] index_pos_d;

    assign run_start  = (state == IDLE) && start;
    assign preset_now = calc_preset(home_q, enc_counter, enc_Z_pos);

    rot_enc_home_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .load       (run_start),
        .load_value (timeout_ticks),
        .dec        ((state == WAIT_RDY) || (state == SEARCH)),
        .expire     (tmr_expire)
    );

    // State register.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic; abort overrides everything while a run is in flight.
    always_comb begin
        next_state = state;
        fail_cause = FAIL_NONE;
        case (state)
            IDLE:     if (start) next_state = CLEAR;
            CLEAR:    next_state = WAIT_RDY;
            WAIT_RDY: begin
                if (tmr_expire) begin
                    next_state = FAIL;
                    fail_cause = FAIL_TIMEOUT;
                end else if (enc_ready) begin
                    next_state = ARM;
                end
            end
            ARM:      next_state = SEARCH;
            SEARCH: begin
                if (enc_error) begin
                    next_state = FAIL;
                    fail_cause = FAIL_ENC_ERR;
                end else if (tmr_expire) begin
                    next_state = FAIL;
                    fail_cause = FAIL_TIMEOUT;
                end else if (enc_Z_flag) begin
                    next_state = LOAD_LO;
                end
            end
            LOAD_LO:  next_state = LOAD_HI;
            LOAD_HI:  next_state = DONE;
            DONE:     next_state = IDLE;
            FAIL:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (abort && (state != IDLE) && (state != DONE) && (state != FAIL)) begin
            next_state = FAIL;
            fail_cause = FAIL_ABORT;
        end
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        sclr_d      = (next_state == CLEAR);
        zclr_d      = (next_state == CLEAR) || (next_state == ARM);
        busy_d      = (next_state != IDLE);
        done_d      = (next_state == DONE);
        fail_d      = (next_state == FAIL);
        drop_d      = cpu_write && !((state == IDLE) && !start);
        ena_d       = enc_ena;
        fail_code_d = fail_code;
        index_pos_d = index_pos;
        write_d     = 1'b0;
        addr_d      = PRESET_LO;
        be_d        = 2'b00;
        data_d      = 16'h0000;

        if ((next_state == CLEAR) || (next_state == FAIL)) ena_d = 1'b0;
        else if (next_state == ARM)                        ena_d = 1'b1;

        if (run_start)                fail_code_d = FAIL_NONE;
        else if (next_state == FAIL)  fail_code_d = fail_cause;

        if (next_state == LOAD_LO) begin
            index_pos_d = enc_Z_pos;
            write_d     = 1'b1;
            addr_d      = PRESET_LO;
            be_d        = 2'b11;
            data_d      = preset_now[15:0];
        end else if (next_state == LOAD_HI) begin
            write_d     = 1'b1;
            addr_d      = PRESET_HI;
            be_d        = 2'b11;
            data_d      = preset_q[31:16];
        end else if (state == IDLE) begin
            write_d     = cpu_write && !start;
            addr_d      = cpu_addr;
            be_d        = cpu_be;
            data_d      = cpu_data;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            enc_sclr    <= 1'b0;
            enc_ena     <= 1'b0;
            enc_Z_clr   <= 1'b0;
            enc_addr    <= 1'b0;
            enc_be      <= 2'b00;
            enc_write   <= 1'b0;
            enc_data    <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FAIL_NONE;
            index_pos   <= '0;
            cpu_wr_drop <= 1'b0;
        end else begin
            enc_sclr    <= sclr_d;
            enc_ena     <= ena_d;
            enc_Z_clr   <= zclr_d;
            enc_addr    <= addr_d;
            enc_be      <= be_d;
            enc_write   <= write_d;
            enc_data    <= data_d;
            busy        <= busy_d;
            done        <= done_d;
            fail        <= fail_d;
            fail_code   <= fail_code_d;
            index_pos   <= index_pos_d;
            cpu_wr_drop <= drop_d;
        end
    end

    // Run parameters and the preset captured at the index; pure data, no reset needed.
    always_ff @(posedge clock) begin
        if (run_start)         home_q   <= home_value;
        if (state == SEARCH)   preset_q <= preset_now;
    end

endmodule
